// File: rtl/memory_access_stage_pkg.sv
// rtl/memory_access_stage_pkg.sv - FSM state encodings and shared defaults for the MEM stage
package memory_access_stage_pkg;

   localparam int DATA_W_DEFAULT = 32;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_ACCESS   = 2'd1,
      ST_COMPLETE = 2'd2
   } state_t;

   function automatic logic is_word_aligned(input logic [1:0] lsb);
      return lsb == 2'b00;
   endfunction

endpackage

// File: rtl/memory_access_stage.sv
// rtl/memory_access_stage.sv - MEM pipeline stage: data-memory loads/stores over req/ack, MW register, branch redirect
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   XM_* / ALUout                 EX/MEM pipeline register (held by upstream while stall=1)
//   dmem_req/we/addr/wdata        registered request to data memory, held stable during ACCESS
//   dmem_rdata, dmem_ack          memory response, sampled only in ACCESS
//   stall                         freezes IF/ID/EX while a memory access is outstanding
//   branch_taken, branch_target   fetch redirect
//   MW_*                          MEM/WB pipeline register
//   misalign_err, bus_err         sticky error flags, cleared only by rst
module memory_access_stage
   import memory_access_stage_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEFAULT,
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              XM_MemtoReg,
   input  logic              XM_RegWrite,
   input  logic              XM_MemRead,
   input  logic              XM_MemWrite,
   input  logic              XM_branch,
   input  logic [DATA_W-1:0] ALUout,
   input  logic [DATA_W-1:0] XM_MD,
   input  logic [4:0]        XM_RD,
   input  logic [DATA_W-1:0] XM_BT,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [DATA_W-1:0] dmem_addr,
   output logic [DATA_W-1:0] dmem_wdata,
   input  logic [DATA_W-1:0] dmem_rdata,
   input  logic              dmem_ack,
   output logic              stall,
   output logic              branch_taken,
   output logic [DATA_W-1:0] branch_target,
   output logic              MW_MemtoReg,
   output logic              MW_RegWrite,
   output logic [DATA_W-1:0] MW_ALUout,
   output logic [DATA_W-1:0] MW_MemData,
   output logic [4:0]        MW_RD,
   output logic              misalign_err,
   output logic              bus_err
);

   localparam bit TO_EN = (TIMEOUT != 0);
   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_EN ? TIMEOUT - 1 : 0);

   state_t            state;
   state_t            state_nxt;
   logic [CNT_W-1:0]  wait_cnt;
   logic [DATA_W-1:0] capt_data;

   logic mem_op;
   logic aligned;
   logic issue;
   logic misalign;
   logic ack_hit;
   logic timeout_hit;

   assign mem_op  = XM_MemRead | XM_MemWrite;
   assign aligned = is_word_aligned(ALUout[1:0]);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:     if (issue) state_nxt = ST_ACCESS;
         ST_ACCESS:   if (ack_hit || timeout_hit) state_nxt = ST_COMPLETE;
         ST_COMPLETE: state_nxt = ST_IDLE;
         default:     state_nxt = ST_IDLE;
      endcase
   end

   // Output / decode logic
   always_comb begin
      issue         = (state == ST_IDLE) & mem_op & aligned;
      misalign      = (state == ST_IDLE) & mem_op & ~aligned;
      ack_hit       = (state == ST_ACCESS) & dmem_ack;
      // ack has priority: a timeout only fires in a cycle without ack
      timeout_hit   = (state == ST_ACCESS) & ~dmem_ack & TO_EN & (wait_cnt == TO_LAST);
      // rst gates stall so upstream is released immediately, even with a mem op parked in XM
      stall         = ~rst & (issue | (state == ST_ACCESS));
      branch_taken  = XM_branch & (state == ST_IDLE);
      branch_target = XM_BT;
   end

   // Datapath: bus request, timeout counter, captured data, MW register, sticky flags
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dmem_req     <= 1'b0;
         dmem_we      <= 1'b0;
         dmem_addr    <= '0;
         dmem_wdata   <= '0;
         wait_cnt     <= '0;
         capt_data    <= '0;
         MW_MemtoReg  <= 1'b0;
         MW_RegWrite  <= 1'b0;
         MW_ALUout    <= '0;
         MW_MemData   <= '0;
         MW_RD        <= '0;
         misalign_err <= 1'b0;
         bus_err      <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               MW_MemtoReg <= XM_MemtoReg;
               MW_ALUout   <= ALUout;
               MW_RD       <= XM_RD;
               // any memory op leaves a bubble here; the real writeback happens from COMPLETE
               MW_RegWrite <= XM_RegWrite & ~mem_op;
               if (misalign) misalign_err <= 1'b1;
               if (issue) begin
                  dmem_req   <= 1'b1;
                  dmem_we    <= XM_MemWrite;
                  dmem_addr  <= ALUout;
                  dmem_wdata <= XM_MD;
                  wait_cnt   <= '0;
                  capt_data  <= '0;
               end
            end
            ST_ACCESS: begin
               if (ack_hit) begin
                  dmem_req <= 1'b0;
                  if (!dmem_we) capt_data <= dmem_rdata;
               end else if (timeout_hit) begin
                  dmem_req  <= 1'b0;
                  bus_err   <= 1'b1;
                  capt_data <= '0;
               end else begin
                  wait_cnt <= wait_cnt + CNT_W'(1);
               end
            end
            ST_COMPLETE: begin
               MW_MemtoReg <= XM_MemtoReg;
               MW_RegWrite <= XM_RegWrite;
               MW_ALUout   <= ALUout;
               MW_RD       <= XM_RD;
               MW_MemData  <= capt_data;
            end
            default: ;
         endcase
      end
   end

endmodule
